// File: rtl/stopwatch_seg_scan.sv
// ---------------------------------------------------------------------------
// stopwatch_seg_scan
//
// Purpose:
//   Drives a 6-digit, common-anode, multiplexed 7-segment display from the
//   stopwatch BCD digit bus. Digits are scanned one slot at a time. Each slot
//   begins with a short guard interval with every anode off, so the previous
//   digit's segments never ghost onto the next digit. All six digits are
//   captured into shadow registers once per frame. A digit bus that changes
//   mid-scan therefore never tears the value on the display.
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   data0..data5 in   4  BCD digits (data0 = least significant, data5 = most)
//   blank        in   1  1 = all anodes inactive; scanning keeps running
//   seg          out  7  segments {g,f,e,d,c,b,a}
//   dp           out  1  decimal point
//   an           out  6  digit enables, an[k] drives digit k
//   frame_done   out  1  one-cycle pulse after each full 6-slot frame
//
// Parameters:
//   SCAN_DIV        clk cycles per digit slot (>= 4)
//   GUARD           dark cycles at the start of each slot (1 .. SCAN_DIV-2)
//   DP_MASK         bit k lights the decimal point in slot k
//   SEG_ACTIVE_LOW  1: seg/dp active-low, 0: active-high
//   AN_ACTIVE_LOW   1: an active-low, 0: active-high
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits 1..5 that are zero and have
//                          only zeros above them are kept dark. Digit 0 is
//                          always shown. When undefined, every digit is shown.
// ---------------------------------------------------------------------------
module stopwatch_seg_scan #(
   parameter int         SCAN_DIV       = 50000,
   parameter int         GUARD          = 16,
   parameter logic [5:0] DP_MASK        = 6'b010100,
   parameter bit         SEG_ACTIVE_LOW = 1'b1,
   parameter bit         AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] data0,
   input  logic [3:0] data1,
   input  logic [3:0] data2,
   input  logic [3:0] data3,
   input  logic [3:0] data4,
   input  logic [3:0] data5,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_done
);

   localparam int            CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

   // Inactive output levels. The active-high values are XORed with these,
   // which both applies the polarity and gives the reset value.
   localparam logic [5:0] AN_OFF  = AN_ACTIVE_LOW  ? 6'h3F : 6'h00;
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

   // BCD to active-high {g,f,e,d,c,b,a}. Codes A-F show a dash (g only) so a
   // corrupted digit is visible on the display instead of being disguised.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          load_q, load_d;
   logic          frame_done_q, frame_done_d;
   logic [3:0]    shadow_q [6];
   logic [3:0]    shadow_d [6];
   logic [5:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tick;
   logic          frame_wrap;
   logic          slot_on;
   logic          suppressed;
   logic [3:0]    data_w [6];

`ifdef LEADING_ZERO_BLANK_EN
   // zero_from[k] is set when digit k and every digit above it are zero.
   // Bit 0 stays clear because the least significant digit is always shown.
   // Each bit is computed directly from the shadow regs, without chaining
   // through its neighbour, so there is no combinational self-loop.
   logic [5:0] zero_from;

   always_comb begin
      zero_from = 6'b111110;
      for (int j = 1; j < 6; j++) begin
         for (int k = 1; k <= j; k++) begin
            if (shadow_q[j] != 4'd0) begin
               zero_from[k] = 1'b0;
            end
         end
      end
   end

   assign suppressed = zero_from[idx_q];
`else
   assign suppressed = 1'b0;
`endif

   // Collect the digit bus into an array so the frame load is one loop.
   always_comb begin
      data_w[0] = data0;
      data_w[1] = data1;
      data_w[2] = data2;
      data_w[3] = data3;
      data_w[4] = data4;
      data_w[5] = data5;
   end

   // Prescaler, slot index, frame load and frame_done. A frame ends on the
   // tick in slot 5. That same condition arms the shadow load, so the inputs
   // are sampled exactly once per frame, in the cycle where idx returns to 0.
   always_comb begin
      tick         = (cnt_q == CNT_MAX);
      frame_wrap   = tick && (idx_q == 3'd5);
      cnt_d        = tick ? '0 : cnt_q + CW'(1);
      idx_d        = idx_q;
      if (tick) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      load_d       = frame_wrap;
      frame_done_d = frame_wrap;
      for (int k = 0; k < 6; k++) begin
         shadow_d[k] = load_q ? data_w[k] : shadow_q[k];
      end
   end

   // Display outputs. They are registered one cycle behind (cnt, idx). The
   // segments always follow the current slot's digit. Only the anode and the
   // decimal point are gated by the guard interval, blank and suppression.
   always_comb begin
      slot_on = (cnt_q >= GUARD_C) && !blank && !suppressed;
      an_d    = (slot_on ? (6'b000001 << idx_q) : 6'b000000) ^ AN_OFF;
      seg_d   = decode(shadow_q[idx_q]) ^ SEG_OFF;
      dp_d    = (slot_on && DP_MASK[idx_q]) ^ DP_OFF;
   end

   // State register. load_q resets to 1 so that the first cycle after reset
   // captures the digit bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         load_q       <= 1'b1;
         frame_done_q <= 1'b0;
         for (int k = 0; k < 6; k++) begin
            shadow_q[k] <= 4'd0;
         end
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         load_q       <= load_d;
         frame_done_q <= frame_done_d;
         for (int k = 0; k < 6; k++) begin
            shadow_q[k] <= shadow_d[k];
         end
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stopwatch_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_seg_scan
//
// Runs stopwatch_seg_scan with SCAN_DIV=8, GUARD=2 and the default
// polarities. Cycle t is counted from the first cycle after reset is
// released. The expected display is derived from t:
//   slot position = (t-1) mod 8
//   digit         = ((t-1) / 8) mod 6
//   digits shown  = the bus values recorded at the most recent frame start
//                   (a multiple of 48)
// ---------------------------------------------------------------------------
module tb_stopwatch_seg_scan;

   localparam int         SCAN_DIV = 8;
   localparam int         GUARD    = 2;
   localparam int         FRAME    = 6 * SCAN_DIV;
   localparam int         MAXT     = 4096;
   localparam logic [5:0] DP_MASK  = 6'b010100;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0, d5 = 4'd0;
   logic       blank = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       frameDone;

   logic [23:0] dataHist  [MAXT];
   logic        blankHist [MAXT];
   int          t           = 0;
   int          nCompared   = 0;
   int          nMismatched = 0;

   stopwatch_seg_scan #(
      .SCAN_DIV       (SCAN_DIV),
      .GUARD          (GUARD),
      .DP_MASK        (DP_MASK),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data0      (d0),
      .data1      (d1),
      .data2      (d2),
      .data3      (d3),
      .data4      (d4),
      .data5      (d5),
      .blank      (blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frameDone)
   );

   always #5 clk = ~clk;

   // Active-high digit patterns.
   function automatic logic [6:0] segCode(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Compares the outputs of cycle t with the values expected from the
   // recorded inputs.
   task automatic checkOutput();
      int          u, c, i;
      logic [23:0] sh;
      bit          sup, on;
      logic [5:0]  expAn;
      logic [6:0]  expSeg;
      logic        expDp, expFd;
      expFd = (t > 0) && (t % FRAME == 0);
      u     = t - 1;
      c     = u % SCAN_DIV;
      i     = (u / SCAN_DIV) % 6;
      sh    = (u == 0) ? 24'h0 : dataHist[((u - 1) / FRAME) * FRAME];
      sup   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0) begin
         sup = 1'b1;
         for (int k = i; k < 6; k++) begin
            if (sh[4*k +: 4] != 4'd0) sup = 1'b0;
         end
      end
`endif
      on     = (c >= GUARD) && !blankHist[u] && !sup;
      expAn  = on ? ~(6'b000001 << i) : 6'h3F;
      expDp  = !(on && DP_MASK[i]);
      expSeg = ~segCode(sh[4*i +: 4]);

      nCompared++;
      assert (frameDone === expFd) else begin
         nMismatched++;
         $error("[TB] FAIL frame_done t=%0d observed=%b expected=%b", t, frameDone, expFd);
      end
      nCompared++;
      assert (an === expAn) else begin
         nMismatched++;
         $error("[TB] FAIL an t=%0d observed=%h expected=%h", t, an, expAn);
      end
      nCompared++;
      assert (dp === expDp) else begin
         nMismatched++;
         $error("[TB] FAIL dp t=%0d observed=%b expected=%b", t, dp, expDp);
      end
      if (!sup) begin
         nCompared++;
         assert (seg === expSeg) else begin
            nMismatched++;
            $error("[TB] FAIL seg t=%0d observed=%h expected=%h", t, seg, expSeg);
         end
      end
   endtask

   task automatic checkReset();
      nCompared++;
      assert (an === 6'h3F && seg === 7'h7F && dp === 1'b1 && frameDone === 1'b0) else begin
         nMismatched++;
         $error("[TB] FAIL reset_state observed an=%h seg=%h dp=%b fd=%b expected an=3f seg=7f dp=1 fd=0",
                an, seg, dp, frameDone);
      end
   endtask

   // Drives one cycle's inputs, records them, and checks the next cycle.
   task automatic applyStimulus(input logic [23:0] digits, input logic b);
      {d5, d4, d3, d2, d1, d0} = digits;
      blank = b;
      dataHist[t]  = digits;
      blankHist[t] = b;
      @(negedge clk);
      t++;
      checkOutput();
   endtask

   task automatic resetPhase(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(negedge clk);
         checkReset();
      end
      reset = 1'b0;
      t     = 0;
   endtask

   function automatic logic [23:0] randDigits();
      logic [23:0] r;
      for (int k = 0; k < 6; k++) begin
         r[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      return r;
   endfunction

   initial begin
      logic [23:0] rd;
      $display("[TB] start");
      resetPhase(3);

      repeat (2 * FRAME) applyStimulus(24'h654321, 1'b0);

      repeat (20) applyStimulus(24'h654321, 1'b0);
      repeat (FRAME - 20 + FRAME) applyStimulus(24'h654329, 1'b0);

      repeat (2 * FRAME) applyStimulus(24'h65C329, 1'b0);

      repeat (100) applyStimulus(24'h65C329, 1'b1);
      repeat (60) applyStimulus(24'h65C329, 1'b0);

      repeat (2 * FRAME) applyStimulus(24'h000507, 1'b0);

      for (int n = 0; n < 300; n++) begin
         if (n % 7 == 0) rd = randDigits();
         applyStimulus(rd, ($urandom_range(0, 7) == 0));
      end

      repeat (13) applyStimulus(24'h123456, 1'b0);
      resetPhase(2);
      rd = randDigits();
      repeat (2 * FRAME + 24) applyStimulus(rd, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
